// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states and frame constants.
// Used by both receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK,
        PARITY
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-cycle pulse every
// round(CLK_HZ / (OVS*BAUD)) clocks, clamped to at least 1.
module uart_baud_tick #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200,
    parameter int OVS    = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int DIV   = (CLK_HZ + (OVS * BAUD) / 2) / (OVS * BAUD);
    localparam int DIV_C = (DIV < 1) ? 1 : DIV;
    localparam int CW    = (DIV_C > 1) ? $clog2(DIV_C) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV_C - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver, 8N1 with valid/ack handoff.
// Define UART_RX_PARITY_EN for 8E1 framing (parity checked).
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam logic [3:0] S_MID  = 4'(MID_SAMPLE);
    localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] B_LAST = 3'(DATA_BITS - 1);

    logic        w_tick;
    logic        w_fall;
    logic        w_keep;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    uart_state_e r_state;
    logic [3:0]  r_scnt;
    logic [2:0]  r_bcnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_ferr;
    logic        r_ovr;

    uart_baud_tick #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD),
        .OVS   (OVERSAMPLE)
    ) u_tick (
        .i_clk (sys_clk),
        .i_rst (rst),
        .o_tick(w_tick)
    );

    assign w_fall = r_prev & ~r_sync2;

`ifdef UART_RX_PARITY_EN
    logic r_perr;
    assign w_keep = ~r_perr;
`else
    assign w_keep = 1'b1;
`endif

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_state <= IDLE;
            r_scnt  <= 4'd0;
            r_bcnt  <= 3'd0;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
            if (rx_ack) begin
                r_valid <= 1'b0;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state <= START;
                        r_scnt  <= 4'd0;
`ifdef UART_RX_PARITY_EN
                        r_perr  <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_scnt == S_MID) begin
                            r_scnt <= 4'd0;
                            r_bcnt <= 3'd0;
                            r_state <= r_sync2 ? IDLE : DATA;
                        end else begin
                            r_scnt <= r_scnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_scnt <= r_scnt + 4'd1;
                        if (r_scnt == S_LAST) begin
                            r_shift[r_bcnt] <= r_sync2;
                            r_bcnt <= r_bcnt + 3'd1;
                            if (r_bcnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= PARITY;
`else
                                r_state <= STOP;
`endif
                            end
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_scnt <= r_scnt + 4'd1;
                        if (r_scnt == S_LAST) begin
                            if (r_sync2 != ^r_shift) begin
                                r_perr <= 1'b1;
                                r_ferr <= 1'b1;
                            end
                            r_state <= STOP;
                        end
                    end
                end
`endif
                STOP: begin
                    if (w_tick) begin
                        r_scnt <= r_scnt + 4'd1;
                        if (r_scnt == S_LAST) begin
                            if (r_sync2) begin
                                r_state <= IDLE;
                                if (w_keep) begin
                                    if (!r_valid || rx_ack) begin
                                        r_data  <= r_shift;
                                        r_valid <= 1'b1;
                                    end else begin
                                        r_ovr <= 1'b1;
                                    end
                                end
                            end else begin
                                r_ferr  <= 1'b1;
                                r_state <= BREAK;
                            end
                        end
                    end
                end
                BREAK: begin
                    if (r_sync2) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_ferr;
    assign rx_overrun   = r_ovr;

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive path: samples the asynchronous `uart_rx` line at 16x the baud rate, reassembles 8N1 frames (LSB first) and presents each byte to the consumer with a valid/ack handshake. It is the receive-side counterpart of the existing transmitter. It sits between the board RX pin and user logic, runs entirely in the `sys_clk` domain and generates its own oversample tick.

## Interface
- `CLK_HZ`, 50_000_000, `sys_clk` frequency in Hz
- `BAUD`, 115200, line rate in bit/s; oversample divider `DIV = round(CLK_HZ / (16*BAUD))`, must be ≥1
- `sys_clk` input 1 — single system clock, all logic rising-edge
- `rst` input 1 — reset, asynchronous, active-high
- `uart_rx` input 1 — serial line, idle high, asynchronous to `sys_clk`
- `rx_data` output 8 — last accepted byte
- `rx_valid` output 1 — level; high while `rx_data` holds an unacknowledged byte
- `rx_ack` input 1 — consumer accepts byte; clears `rx_valid` next cycle
- `rx_frame_err` output 1 — one-cycle pulse: stop bit sampled low
- `rx_overrun` output 1 — one-cycle pulse: frame completed while `rx_valid` high and no `rx_ack`

## Operation
- `uart_rx` passes a 2-flop synchronizer; both flops reset to 0, so no start edge is detected after reset until the line has been seen high.
- Tick generator: counter 0..DIV-1, `tick` high one cycle when counter wraps; free-running, reset to 0.
- Sample counter `scnt` (4 bits) counts ticks within a bit; bit counter `bcnt` (3 bits) indexes data bits.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: falling edge on synchronized line (prev 1, cur 0) → START, `scnt`←0.
  - START: at `scnt`==7 (mid start bit) sample; low → DATA, `scnt`←0, `bcnt`←0; high → IDLE (glitch rejected).
  - DATA: at `scnt`==15 sample into shift register bit `bcnt`; after `bcnt`==7 → STOP.
  - STOP: at `scnt`==15 sample; high → frame good, IDLE; low → `rx_frame_err` pulse, BREAK.
  - BREAK: wait until synchronized line high, then IDLE.
- Good frame completion: if `rx_valid`==0 or `rx_ack`==1 this cycle → load `rx_data`, `rx_valid`←1. Otherwise keep old byte, drop new, pulse `rx_overrun`.
- `rx_ack` with `rx_valid`==0 is ignored. Frame-error bytes never load `rx_data`.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`=0, `rx_frame_err`=0, `rx_overrun`=0, FSM=IDLE, all counters 0.
- Latency: `rx_valid` rises ≈ 2 sync cycles + 9.5 bit times + 1 `sys_clk` after the start-bit falling edge (stop sampled mid-bit, flag registered next cycle).
- `rx_valid` falls the cycle after `rx_ack` sampled high; simultaneous ack + completion: `rx_valid` stays 1, new byte loaded, no overrun.
- Error pulses exactly one `sys_clk` wide.
- `rst` asserted mid-frame: immediate return to reset values; partial byte discarded; reception resumes only after the line returns high.
- Tolerates ±3% baud mismatch (mid-bit sampling, no resync within frame).

## Configuration
- `UART_RX_PARITY_EN` defined: frame is 8E1; PARITY state inserted between DATA and STOP, sampled at `scnt`==15; mismatch → byte discarded, `rx_frame_err` pulse, FSM continues to STOP then IDLE/BREAK as normal. Port list unchanged.
- Undefined: 8N1 only, no PARITY state.

## Structure
- Shared package `uart_pkg`: FSM state enum (IDLE, START, DATA, STOP, BREAK, PARITY), `OVERSAMPLE`=16, `MID_SAMPLE`=7, `DATA_BITS`=8; reused by transmitter-side code.
- One sub-module: `uart_baud_tick` (parameters `CLK_HZ`, `BAUD`, `OVS`; outputs one-cycle `tick`); the receiver instantiates it with `OVS`=16.

## Test plan
- Sim params `CLK_HZ`=1_600_000, `BAUD`=100_000 (DIV=1, 16 cycles/bit). Send 0x55 → `rx_valid`=1, `rx_data`=0x55 ≈152 cycles after start edge; no error pulses.
- Send 0xA3 then 0x0F back-to-back, ack after each → two valid bytes, in order, `rx_overrun` never pulses.
- Send 0x12, no ack, send 0x34 → `rx_overrun` one-cycle pulse, `rx_data` stays 0x12; ack → `rx_valid` 0 next cycle.
- Send 0xFF with stop bit forced low, line held low 40 cycles → `rx_frame_err` pulse, `rx_valid` stays 0; then 0x81 → received correctly after line high.
- 4-cycle low glitch on idle line → no START acceptance, no outputs change.
- Assert `rst` during bit 3 of 0xC6 with line low → outputs zero immediately; after release, next frame 0x3C received correctly. With `UART_RX_PARITY_EN`: 0x3C with wrong parity → `rx_frame_err`, no valid.
